// File: rtl/can_core_pkg.sv
// Shared CAN core constants: frame geometry, identifier placement and default FIFO depth.
package can_core_pkg;

    localparam int unsigned FRAME_WIDTH   = 128;
    localparam int unsigned ID_WIDTH      = 11;
    // Identifier occupies the top ID_WIDTH bits of a frame.
    localparam int unsigned ID_MSB        = FRAME_WIDTH - 1;
    localparam int unsigned ID_LSB        = FRAME_WIDTH - ID_WIDTH;
    localparam int unsigned DEFAULT_DEPTH = 64;

    typedef logic [ID_WIDTH-1:0] can_id_t;

endpackage

// File: rtl/rx_acceptance_filter.sv
// Combinational acceptance filter: a frame passes when filtering is off or all masked ID bits match.
module rx_acceptance_filter
    import can_core_pkg::*;
(
    input  logic                afr_en,
    input  logic [ID_WIDTH-1:0] afr_id,
    input  logic [ID_WIDTH-1:0] afr_mask,
    input  logic [ID_WIDTH-1:0] id,
    output logic                pass
);

    always_comb begin
        pass = !afr_en || (((id ^ afr_id) & afr_mask) == '0);
    end

endmodule

// File: rtl/rx_storage_fifo.sv
// Receive frame FIFO with acceptance filtering, overrun flag and saturating reject counter.
module rx_storage_fifo
    import can_core_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned WIDTH = FRAME_WIDTH
) (
    input  logic                       sys_clk,
    input  logic                       IP2Can_reset,
    input  logic [WIDTH-1:0]           rxfifo_ip,
    input  logic                       rx_store,
    input  logic                       rx_read,
    input  logic                       afr_en,
    input  logic [ID_WIDTH-1:0]        afr_id,
    input  logic [ID_WIDTH-1:0]        afr_mask,
    input  logic                       ovr_clr,
    output logic [WIDTH-1:0]           rxfifo_op,
    output logic                       rxfifo_op_vld,
    output logic [$clog2(DEPTH):0]     count2,
    output logic                       RXEMP,
    output logic                       RXFLL,
    output logic                       rx_ovr,
    output logic [7:0]                 rej_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic             vld_q, vld_d;
    logic             ovr_q, ovr_d;
    logic [7:0]       rej_q, rej_d;

    logic pass;
    logic empty, full;
    logic wr_ok, rd_ok, wr_en, ovr_set;

    rx_acceptance_filter u_filter (
        .afr_en   (afr_en),
        .afr_id   (afr_id),
        .afr_mask (afr_mask),
        .id       (rxfifo_ip[WIDTH-1 -: ID_WIDTH]),
        .pass     (pass)
    );

    // Flags come from the registered count only.
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    always_comb begin
        wr_ok    = rx_store && pass;
        rd_ok    = rx_read && !empty;
        wr_en    = wr_ok && (!full || rd_ok);
        ovr_set  = wr_ok && full && !rd_ok;

        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d  = count_q;
        case ({wr_en, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Read uses the pre-edge array, so a full-FIFO store+read overwriting rd_ptr is safe.
        op_d  = rd_ok ? mem_q[rd_ptr_q] : op_q;
        vld_d = rd_ok;

        ovr_d = ovr_q;
        if (ovr_set)      ovr_d = 1'b1;
        else if (ovr_clr) ovr_d = 1'b0;

        rej_d = rej_q;
        if (rx_store && !pass && rej_q != 8'hFF) rej_d = rej_q + 8'd1;
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= rxfifo_ip;
    end

    always_ff @(posedge sys_clk or posedge IP2Can_reset) begin
        if (IP2Can_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            op_q     <= '0;
            vld_q    <= 1'b0;
            ovr_q    <= 1'b0;
            rej_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            op_q     <= op_d;
            vld_q    <= vld_d;
            ovr_q    <= ovr_d;
            rej_q    <= rej_d;
        end
    end

    assign rxfifo_op     = op_q;
    assign rxfifo_op_vld = vld_q;
    assign count2        = count_q;
    assign RXEMP         = empty;
    assign RXFLL         = full;
    assign rx_ovr        = ovr_q;
    assign rej_cnt       = rej_q;

endmodule

// File: tb/tb_rx_storage_fifo.sv
// Directed self-checking bench for rx_storage_fifo with hand-computed expectations.
module tb_rx_storage_fifo;

    localparam int unsigned W  = 128;
    localparam int unsigned PW = W - 11;

    logic          sys_clk = 1'b0;
    logic          IP2Can_reset = 1'b1;
    logic [W-1:0]  rxfifo_ip = '0;
    logic          rx_store = 1'b0;
    logic          rx_read = 1'b0;
    logic          afr_en = 1'b0;
    logic [10:0]   afr_id = '0;
    logic [10:0]   afr_mask = '0;
    logic          ovr_clr = 1'b0;
    logic [W-1:0]  rxfifo_op;
    logic          rxfifo_op_vld;
    logic [6:0]    count2;
    logic          RXEMP, RXFLL, rx_ovr;
    logic [7:0]    rej_cnt;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    rx_storage_fifo #(.DEPTH(64), .WIDTH(128)) dut (
        .sys_clk       (sys_clk),
        .IP2Can_reset  (IP2Can_reset),
        .rxfifo_ip     (rxfifo_ip),
        .rx_store      (rx_store),
        .rx_read       (rx_read),
        .afr_en        (afr_en),
        .afr_id        (afr_id),
        .afr_mask      (afr_mask),
        .ovr_clr       (ovr_clr),
        .rxfifo_op     (rxfifo_op),
        .rxfifo_op_vld (rxfifo_op_vld),
        .count2        (count2),
        .RXEMP         (RXEMP),
        .RXFLL         (RXFLL),
        .rx_ovr        (rx_ovr),
        .rej_cnt       (rej_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [W-1:0] mk(input logic [10:0] id, input int unsigned p);
        return {id, PW'(p)};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after each rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic store(input logic [W-1:0] f);
        rxfifo_ip = f;
        rx_store  = 1'b1;
        tick();
        rx_store  = 1'b0;
    endtask

    task automatic rd();
        rx_read = 1'b1;
        tick();
        rx_read = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_count", W'(count2), W'(0));
        chk("rst_emp",   W'(RXEMP), W'(1));
        chk("rst_fll",   W'(RXFLL), W'(0));
        chk("rst_ovr",   W'(rx_ovr), W'(0));
        chk("rst_rej",   W'(rej_cnt), W'(0));
        chk("rst_vld",   W'(rxfifo_op_vld), W'(0));
        chk("rst_op",    rxfifo_op, W'(0));
        #2 IP2Can_reset = 1'b0;
        tick();

        // In-order read of three frames
        store(mk(11'h100, 1)); store(mk(11'h101, 2)); store(mk(11'h102, 3));
        chk("order_cnt3", W'(count2), W'(3));
        chk("order_emp0", W'(RXEMP), W'(0));
        for (int i = 0; i < 3; i++) begin
            rd();
            chk("order_vld", W'(rxfifo_op_vld), W'(1));
            chk("order_id",  W'(rxfifo_op[W-1 -: 11]), W'(11'h100 + i));
        end
        tick();
        chk("order_vld_once", W'(rxfifo_op_vld), W'(0));
        chk("order_cnt0", W'(count2), W'(0));
        chk("order_emp1", W'(RXEMP), W'(1));

        // Fill, overrun, drain
        for (int i = 0; i < 64; i++) store(mk(11'(i), i));
        chk("full_cnt", W'(count2), W'(64));
        chk("full_fll", W'(RXFLL), W'(1));
        chk("full_ovr0", W'(rx_ovr), W'(0));
        store(mk(11'h7FF, 999));
        chk("ovr_set", W'(rx_ovr), W'(1));
        chk("ovr_cnt", W'(count2), W'(64));
        for (int i = 0; i < 64; i++) begin
            rd();
            chk("drain_data", rxfifo_op, mk(11'(i), i));
        end
        chk("drain_emp", W'(RXEMP), W'(1));
        chk("ovr_sticky", W'(rx_ovr), W'(1));
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        chk("ovr_clr", W'(rx_ovr), W'(0));
        rd();
        chk("emp_read_vld", W'(rxfifo_op_vld), W'(0));
        chk("emp_read_hold", rxfifo_op, mk(11'd63, 63));

        // Full FIFO with simultaneous store and read
        for (int i = 0; i < 64; i++) store(mk(11'(i + 200), i + 1000));
        rxfifo_ip = mk(11'h555, 4242);
        rx_store = 1'b1; rx_read = 1'b1;
        tick();
        rx_store = 1'b0; rx_read = 1'b0;
        chk("fullrw_vld", W'(rxfifo_op_vld), W'(1));
        chk("fullrw_op",  rxfifo_op, mk(11'd200, 1000));
        chk("fullrw_cnt", W'(count2), W'(64));
        chk("fullrw_ovr", W'(rx_ovr), W'(0));
        for (int i = 1; i < 64; i++) begin
            rd();
            chk("fullrw_drain", rxfifo_op, mk(11'(i + 200), i + 1000));
        end
        rd();
        chk("fullrw_last", rxfifo_op, mk(11'h555, 4242));
        chk("fullrw_emp", W'(RXEMP), W'(1));

        // Acceptance filter
        afr_en = 1'b1; afr_id = 11'h120; afr_mask = 11'h7F0;
        store(mk(11'h123, 7));
        store(mk(11'h223, 8));
        chk("flt_cnt", W'(count2), W'(1));
        chk("flt_rej", W'(rej_cnt), W'(1));
        for (int i = 0; i < 300; i++) store(mk(11'h223, i));
        chk("flt_sat", W'(rej_cnt), W'(255));
        chk("flt_cnt2", W'(count2), W'(1));
        afr_id = 11'h000; afr_mask = 11'h7FF;
        rd();
        chk("flt_data", rxfifo_op, mk(11'h123, 7));
        afr_en = 1'b0;

        // Empty FIFO with simultaneous store and read: no fall-through
        rxfifo_ip = mk(11'h3AA, 55);
        rx_store = 1'b1; rx_read = 1'b1;
        tick();
        rx_store = 1'b0; rx_read = 1'b0;
        chk("emprw_vld", W'(rxfifo_op_vld), W'(0));
        chk("emprw_cnt", W'(count2), W'(1));
        rd();
        chk("emprw_vld2", W'(rxfifo_op_vld), W'(1));
        chk("emprw_op",  rxfifo_op, mk(11'h3AA, 55));

        // Wrap-around, then asynchronous reset mid-cycle with a read in flight
        for (int i = 0; i < 100; i++) begin
            store(mk(11'(i), i + 5000));
            rd();
            if (i == 99) chk("wrap_last", rxfifo_op, mk(11'd99, 5099));
        end
        chk("wrap_cnt", W'(count2), W'(0));
        for (int i = 0; i < 5; i++) store(mk(11'(i + 300), i));
        chk("pre_rst_cnt", W'(count2), W'(5));
        rx_read = 1'b1;
        #2 IP2Can_reset = 1'b1;
        #1;
        chk("arst_cnt", W'(count2), W'(0));
        chk("arst_emp", W'(RXEMP), W'(1));
        chk("arst_fll", W'(RXFLL), W'(0));
        chk("arst_op",  rxfifo_op, W'(0));
        chk("arst_rej", W'(rej_cnt), W'(0));
        chk("arst_vld", W'(rxfifo_op_vld), W'(0));
        tick();
        chk("arst_vld_edge", W'(rxfifo_op_vld), W'(0));
        rx_read = 1'b0;
        #2 IP2Can_reset = 1'b0;
        tick();
        chk("post_rst_vld", W'(rxfifo_op_vld), W'(0));
        store(mk(11'h0AB, 77));
        store(mk(11'h0AC, 78));
        rd();
        chk("post_rst_first", rxfifo_op, mk(11'h0AB, 77));
        chk("post_rst_cnt", W'(count2), W'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rx_storage_fifo.md
RX_STORAGE_FIFO -- requirements
Module: rx_storage_fifo

Interface
REQ-001 The block SHALL have the parameter DEPTH, default 64, giving the number of stored frames (power of two).
REQ-002 The block SHALL have the parameter WIDTH, default 128, giving the frame width in bits.
REQ-003 The block SHALL have one clock, sys_clk, and an asynchronous, active-high reset, IP2Can_reset.
REQ-004 sys_clk  in  1  system clock; all state SHALL change on its rising edge.
REQ-005 IP2Can_reset  in  1  asynchronous active-high reset.
REQ-006 rxfifo_ip  in  WIDTH  received frame from the bit-stream receiver; bits [WIDTH-1:WIDTH-11] hold the 11-bit identifier.
REQ-007 rx_store  in  1  one-cycle strobe marking rxfifo_ip as a complete frame.
REQ-008 rx_read  in  1  host pop request.
REQ-009 afr_en  in  1  acceptance-filter enable.
REQ-010 afr_id  in  11  acceptance identifier.
REQ-011 afr_mask  in  11  acceptance mask; 1 = bit compared.
REQ-012 ovr_clr  in  1  clears the overrun flag.
REQ-013 rxfifo_op  out  WIDTH  registered popped frame.
REQ-014 rxfifo_op_vld  out  1  one-cycle pulse qualifying rxfifo_op.
REQ-015 count2  out  log2(DEPTH)+1  stored-frame count, 0..DEPTH.
REQ-016 RXEMP  out  1  count2 == 0.
REQ-017 RXFLL  out  1  count2 == DEPTH.
REQ-018 rx_ovr  out  1  sticky overrun flag.
REQ-019 rej_cnt  out  8  saturating count of frames rejected by the filter.

Function
REQ-020 A frame SHALL pass the filter when afr_en=0, or when ((ID xor afr_id) and afr_mask) = 0.
REQ-021 When rx_store=1 and the frame fails the filter, the frame SHALL be discarded and rej_cnt SHALL increment, holding at 255.
REQ-022 A passing frame SHALL be written at the write pointer, and the pointer SHALL advance, when the FIFO is not full or a valid read occurs in the same cycle.
REQ-023 A passing frame arriving while RXFLL=1 with no same-cycle read SHALL be dropped, leave contents and pointers unchanged, and set rx_ovr.
REQ-024 A read SHALL be valid when rx_read=1 and RXEMP=0; rxfifo_op SHALL then present the entry at the read pointer on the next edge, with rxfifo_op_vld=1 for exactly that cycle.
REQ-025 rx_read while RXEMP=1 SHALL be ignored; rxfifo_op SHALL hold its value and rxfifo_op_vld SHALL stay 0.
REQ-026 Simultaneous store and read while empty SHALL write only; there SHALL be no fall-through, so the frame becomes readable on the following cycle.
REQ-027 Simultaneous valid store and valid read SHALL leave count2 unchanged.
REQ-028 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap DEPTH-1 -> 0 by natural overflow; count2 SHALL be a separate up/down counter.
REQ-029 RXEMP and RXFLL SHALL be decoded from the registered count2, with no combinational path from any input.
REQ-030 ovr_clr=1 SHALL clear rx_ovr; if an overrun occurs in the same cycle, setting SHALL take priority.
REQ-031 Filter settings SHALL be sampled only in a cycle where rx_store=1; changing them never alters stored frames.

Reset
REQ-032 While IP2Can_reset=1, regardless of sys_clk, the pointers, count2, rx_ovr, rej_cnt and rxfifo_op_vld SHALL be 0, RXEMP SHALL be 1, and RXFLL SHALL be 0.
REQ-033 Reset SHALL clear rxfifo_op to 0; storage array contents SHALL NOT be reset.
REQ-034 Reset asserted mid-operation SHALL abort any in-flight read, so no rxfifo_op_vld pulse follows; the first frame stored after release SHALL be the first frame read.

Structure
REQ-035 The shared package can_core_pkg SHALL hold the frame width, identifier width, identifier bit position and default depth.
REQ-036 Filtering SHALL be a sub-module, rx_acceptance_filter (combinational match, ID in, pass out); the storage array and pointer logic SHALL stay in rx_storage_fifo.

Verification
REQ-037 Reset, then store frames with IDs 0x100, 0x101, 0x102 and read 3 times -> rxfifo_op IDs arrive in order 0x100, 0x101, 0x102, each with one vld pulse, and count2 ends at 0.
REQ-038 Store 64 frames (RXFLL=1), then store a 65th -> rx_ovr=1, count2=64, and the 64 reads return the first 64 frames; ovr_clr -> rx_ovr=0.
REQ-039 With the FIFO full, store and read in the same cycle -> count2 stays 64, rx_ovr stays 0, and the new frame is read last.
REQ-040 afr_en=1, afr_id=0x120, afr_mask=0x7F0; store IDs 0x123 and 0x223 -> only 0x123 is stored and rej_cnt=1; 300 rejects -> rej_cnt=255.
REQ-041 With the FIFO empty, store and read in the same cycle -> no vld pulse and count2=1; a read next cycle returns the frame.
REQ-042 Run 100 store/read pairs for wrap-around, then assert reset asynchronously between clock edges with count2=5 -> outputs zero immediately and RXEMP=1.
